// File: rtl/can_fd_data_field.sv
// CAN / CAN FD data-field serializer: DLC decode, MSB-first shift-out on sample_point.
// Optional dynamic bit stuffing is compiled in with `define DATA_STUFF_EN.
module can_fd_data_field #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   sample_point,
  input  logic                   Tx_request,
  input  logic                   control_complete,
  input  logic                   fd_mode,
  input  logic [3:0]             dlc,
  input  logic [MAX_BYTES*8-1:0] data,
  input  logic                   prev_bit,
  input  logic [2:0]             prev_run,
  output logic                   data_bit,
  output logic [CNT_W-1:0]       bit_counter,
  output logic [6:0]             data_length,
  output logic                   stuff_bit,
  output logic                   data_active,
  output logic                   data_complete,
  output logic                   dlc_error
);

  localparam int DW = MAX_BYTES * 8;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, COMPLETE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0] bit_counter_q, bit_counter_d;
  logic [6:0]       data_length_q, data_length_d;
  logic             dlc_error_q, dlc_error_d;
  logic             data_bit_q, data_bit_d;
  logic             data_active_q, data_active_d;
  logic             data_complete_q, data_complete_d;

  logic [6:0]       len_dec, len_ld;
  logic             len_over;
  logic [CNT_W-1:0] total_bits, cnt_inc;

`ifdef DATA_STUFF_EN
  logic             stuff_q, stuff_d;
  logic             last_q, last_d;
  logic [2:0]       run_q, run_d;
`else
  logic             unused_prev;
  assign unused_prev = ^{prev_bit, prev_run};
`endif

  function automatic logic [6:0] decode_len(input logic fd, input logic [3:0] code);
    if (code <= 4'd8) return {3'b000, code};
    if (!fd)          return 7'd8;
    case (code)
      4'd9:    return 7'd12;
      4'd10:   return 7'd16;
      4'd11:   return 7'd20;
      4'd12:   return 7'd24;
      4'd13:   return 7'd32;
      4'd14:   return 7'd48;
      default: return 7'd64;
    endcase
  endfunction

  always_comb begin
    len_dec    = decode_len(fd_mode, dlc);
    len_over   = len_dec > 7'(MAX_BYTES);
    len_ld     = len_over ? 7'(MAX_BYTES) : len_dec;
    total_bits = CNT_W'({data_length_q, 3'b000});
    cnt_inc    = bit_counter_q + CNT_W'(1);

    state_d       = state_q;
    sr_d          = sr_q;
    bit_counter_d = bit_counter_q;
    data_length_d = data_length_q;
    dlc_error_d   = dlc_error_q;
`ifdef DATA_STUFF_EN
    stuff_d = stuff_q;
    last_d  = last_q;
    run_d   = run_q;
`endif

    case (state_q)
      IDLE: if (enable && Tx_request && control_complete) state_d = LOAD;
      LOAD: begin
        sr_d          = data;
        data_length_d = len_ld;
        dlc_error_d   = len_over;
        bit_counter_d = '0;
        state_d       = (len_ld == 7'd0) ? COMPLETE : SEND;
`ifdef DATA_STUFF_EN
        // A preceding field that ended on a full run owes a stuff bit first.
        last_d  = prev_bit;
        run_d   = prev_run;
        stuff_d = (prev_run == 3'd5) && (len_ld != 7'd0);
`endif
      end
      SEND: if (sample_point) begin
`ifdef DATA_STUFF_EN
        if (stuff_q) begin
          stuff_d = 1'b0;
          last_d  = ~last_q;
          run_d   = 3'd1;
          if (bit_counter_q == total_bits) state_d = COMPLETE;
        end else begin
          sr_d          = sr_q << 1;
          bit_counter_d = cnt_inc;
          last_d        = sr_q[DW-1];
          run_d         = (sr_q[DW-1] == last_q) ? run_q + 3'd1 : 3'd1;
          // A completed run defers COMPLETE until its stuff bit is out.
          if (run_d == 3'd5)            stuff_d = 1'b1;
          else if (cnt_inc == total_bits) state_d = COMPLETE;
        end
`else
        sr_d          = sr_q << 1;
        bit_counter_d = cnt_inc;
        if (cnt_inc == total_bits) state_d = COMPLETE;
`endif
      end
      COMPLETE: if (!Tx_request) begin
        state_d       = IDLE;
        bit_counter_d = '0;
        dlc_error_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d       = IDLE;
      bit_counter_d = '0;
      dlc_error_d   = 1'b0;
`ifdef DATA_STUFF_EN
      stuff_d = 1'b0;
`endif
    end

    // Outputs are registered from next-state values so they line up with state_q.
    data_active_d   = (state_d == SEND);
    data_complete_d = (state_d == COMPLETE);
`ifdef DATA_STUFF_EN
    data_bit_d = (state_d == SEND) ? (stuff_d ? ~last_d : sr_d[DW-1]) : 1'b1;
`else
    data_bit_d = (state_d == SEND) ? sr_d[DW-1] : 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      sr_q            <= '0;
      bit_counter_q   <= '0;
      data_length_q   <= '0;
      dlc_error_q     <= 1'b0;
      data_bit_q      <= 1'b1;
      data_active_q   <= 1'b0;
      data_complete_q <= 1'b0;
`ifdef DATA_STUFF_EN
      stuff_q <= 1'b0;
      last_q  <= 1'b1;
      run_q   <= 3'd1;
`endif
    end else begin
      state_q         <= state_d;
      sr_q            <= sr_d;
      bit_counter_q   <= bit_counter_d;
      data_length_q   <= data_length_d;
      dlc_error_q     <= dlc_error_d;
      data_bit_q      <= data_bit_d;
      data_active_q   <= data_active_d;
      data_complete_q <= data_complete_d;
`ifdef DATA_STUFF_EN
      stuff_q <= stuff_d;
      last_q  <= last_d;
      run_q   <= run_d;
`endif
    end
  end

  assign data_bit      = data_bit_q;
  assign bit_counter   = bit_counter_q;
  assign data_length   = data_length_q;
  assign dlc_error     = dlc_error_q;
  assign data_active   = data_active_q;
  assign data_complete = data_complete_q;
`ifdef DATA_STUFF_EN
  assign stuff_bit = stuff_q;
`else
  assign stuff_bit = 1'b0;
`endif

endmodule
